fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-002 Parameter RESET_PC, 32'h0000_0000: PC value loaded at reset.
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port PC_Enable, input, 1: 1 = pipeline advances; 0 = freeze the PC and IF/ID register (hazard stall).
REQ-006 Port Branch_Taken, Jump, JR, inputs, 1 each: redirect requests from decode; priority is JR > Jump > Branch_Taken.
REQ-007 Port Branch_Target, Jump_Target, JR_Target, inputs, 32 each: redirect addresses.
REQ-008 Port Imem_Req, output, 1: instruction memory request.
REQ-009 Port Imem_Addr, output, 32: fetch address, equal to the current PC.
REQ-010 Port Imem_Ready, input, 1: one-cycle pulse; Imem_RD is valid in the same cycle.
REQ-011 Port Imem_RD, input, 32: fetched word.
REQ-012 Port Instr_D, output, 32: IF/ID instruction; 32'h0000_0000 (nop) when Valid_D=0.
REQ-013 Port PC_Plus4_D, output, 32: IF/ID PC+4 of Instr_D.
REQ-014 Port Valid_D, output, 1: IF/ID holds a real instruction.

Function
REQ-015 The block SHALL implement states FETCH, HOLD and DISCARD.
REQ-016 Redirect is asserted when any of JR, Jump or Branch_Taken is 1; the target is chosen by REQ-006 priority.
REQ-017 Redirect SHALL be ignored while PC_Enable=0, because decode re-presents it.
REQ-018 Imem_Req SHALL be 1 in FETCH and DISCARD and 0 in HOLD.
REQ-019 Imem_Addr SHALL stay stable from request until Imem_Ready.
REQ-020 FETCH, Ready=1, Enable=1, no redirect: IF/ID <= {Imem_RD, PC+4, valid}; PC <= PC+4; stay in FETCH.
REQ-021 FETCH, Ready=1, Enable=1, redirect: IF/ID <= nop (wrong-path word squashed); PC <= target; stay in FETCH.
REQ-022 FETCH, Ready=1, Enable=0: buffer Imem_RD in the skid register; IF/ID holds; go to HOLD.
REQ-023 FETCH, Ready=0, Enable=1: IF/ID <= nop; on redirect, save the target in Redirect_PC and go to DISCARD.
REQ-024 FETCH, Ready=0, Enable=0: hold all state.
REQ-025 HOLD, Enable=1: IF/ID <= {skid, PC+4, valid} and PC <= PC+4; or, on redirect, IF/ID <= nop and PC <= target; go to FETCH.
REQ-026 HOLD, Enable=0: hold.
REQ-027 DISCARD: Enable=1 writes nop to IF/ID, and a newer redirect overwrites Redirect_PC.
REQ-028 DISCARD, Ready=1: drop Imem_RD; PC <= Redirect_PC (or the newer target if redirect occurs in the same cycle); go to FETCH.
REQ-029 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-030 Instr_D, PC_Plus4_D and Valid_D SHALL change only on clock edges; IF/ID latency is one cycle from Imem_Ready.

Reset
REQ-031 rst_n=0 SHALL immediately set PC=RESET_PC, state=FETCH, Valid_D=0, Instr_D=0, PC_Plus4_D=0, skid=0 and Redirect_PC=0.
REQ-032 Reset mid-request SHALL abandon the outstanding fetch; the first post-reset request SHALL use RESET_PC.

Structure
REQ-033 A shared package SHALL hold the state enum, NOP_INSTR=32'h0 and the default RESET_PC.
REQ-034 One sub-module, if_id_reg, SHALL implement the enable/flush IF/ID register.

Verification
REQ-035 Reset, Ready every cycle, Enable=1: Imem_Addr = 0, 4, 8; Valid_D rises one cycle after the first Ready.
REQ-036 Ready on the fetch of 0x8 with Enable=0 for 2 cycles: state = HOLD, Imem_Req=0; on release, Instr_D = buffered word and PC_Plus4_D = 0xC.
REQ-037 Branch_Taken=1 with Branch_Target=0x40 while Ready=1: next Instr_D = nop and Valid_D=0; next Imem_Addr = 0x40.
REQ-038 Jump=1 with Jump_Target=0x80 while Ready=0: Imem_Addr stays at the old PC until Ready; data is dropped, then Imem_Addr = 0x80.
REQ-039 JR=1 (0x100) and Branch_Taken=1 (0x40) together: next Imem_Addr = 0x100; with Enable=0, the redirect is ignored.
REQ-040 rst_n pulsed low during the DISCARD state: outputs clear asynchronously and Imem_Addr = RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Purpose : shared types and constants for the instruction fetch stage.
// Latency : n/a (package only).
// Backpressure: n/a.
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,   // request outstanding, result used when it arrives
      HOLD    = 2'd1,   // word fetched while stalled, parked in skid register
      DISCARD = 2'd2    // redirected while a fetch was in flight; drop its data
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Redirect target selection: JR beats Jump beats Branch_Taken.
   function automatic logic [31:0] redirect_target(
      input logic        jr,
      input logic        jump,
      input logic [31:0] jr_target,
      input logic [31:0] jump_target,
      input logic [31:0] branch_target
   );
      if (jr)
         return jr_target;
      else if (jump)
         return jump_target;
      else
         return branch_target;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Purpose : instruction memory request/response bundle for the fetch stage.
// Latency : n/a (wires only); Imem_RD is valid in the cycle Imem_Ready pulses.
// Backpressure: memory stretches a request simply by holding Imem_Ready low.
// Ports   : Imem_Req/Imem_Addr (fetch -> memory), Imem_Ready/Imem_RD (memory -> fetch).
interface fetch_stage_if;
   logic        Imem_Req;
   logic [31:0] Imem_Addr;
   logic        Imem_Ready;
   logic [31:0] Imem_RD;

   modport master (output Imem_Req, output Imem_Addr, input Imem_Ready, input Imem_RD);
   modport slave  (input Imem_Req, input Imem_Addr, output Imem_Ready, output Imem_RD);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Purpose : IF/ID pipeline register with load and flush (flush inserts a nop).
// Latency : one cycle from ld/flush to outputs.
// Backpressure: neither ld nor flush asserted -> contents held (stall).
// Ports   : clk, rst_n, ld, flush, instr_i, pc4_i -> instr_q, pc4_q, valid_q.
module if_id_reg
   import fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld,
   input  logic        flush,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc4_i,
   output logic [31:0] instr_q,
   output logic [31:0] pc4_q,
   output logic        valid_q
);

   logic [31:0] instr_d;
   logic [31:0] pc4_d;
   logic        valid_d;

   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (flush) begin
         instr_d = NOP_INSTR;
         pc4_d   = 32'h0;
         valid_d = 1'b0;
      end else if (ld) begin
         instr_d = instr_i;
         pc4_d   = pc4_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= NOP_INSTR;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Purpose : PC sequencing, instruction memory requests and IF/ID register.
// Latency : IF/ID updated one cycle after Imem_Ready (or after stall release).
// Backpressure: PC_Enable=0 freezes PC and IF/ID; a word arriving then is skid-buffered.
// Ports   : clk, rst_n, PC_Enable, Branch_Taken/Jump/JR + targets, imem (master),
//           Instr_D, PC_Plus4_D, Valid_D.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 PC_Enable,
   input  logic                 Branch_Taken,
   input  logic                 Jump,
   input  logic                 JR,
   input  logic [31:0]          Branch_Target,
   input  logic [31:0]          Jump_Target,
   input  logic [31:0]          JR_Target,
   fetch_stage_if.master        imem,
   output logic [31:0]          Instr_D,
   output logic [31:0]          PC_Plus4_D,
   output logic                 Valid_D
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  skid_q, skid_d;
   logic [31:0]  redirect_pc_q, redirect_pc_d;

   logic         ifid_ld;
   logic         ifid_flush;
   logic [31:0]  ifid_instr;
   logic [31:0]  pc_plus4;
   logic         redirect;
   logic [31:0]  target;

   // Decode keeps presenting a redirect across a stall, so it only counts when enabled.
   assign redirect = PC_Enable & (JR | Jump | Branch_Taken);
   assign target   = redirect_target(JR, Jump, JR_Target, Jump_Target, Branch_Target);
   assign pc_plus4 = pc_q + 32'd4;

   assign imem.Imem_Req  = (state_q != HOLD);
   assign imem.Imem_Addr = pc_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      skid_d        = skid_q;
      redirect_pc_d = redirect_pc_q;
      ifid_ld       = 1'b0;
      ifid_flush    = 1'b0;
      ifid_instr    = skid_q;

      case (state_q)
         FETCH: begin
            if (imem.Imem_Ready) begin
               if (PC_Enable) begin
                  if (redirect) begin
                     ifid_flush = 1'b1;   // squash the wrong-path word
                     pc_d       = target;
                  end else begin
                     ifid_ld    = 1'b1;
                     ifid_instr = imem.Imem_RD;
                     pc_d       = pc_plus4;
                  end
               end else begin
                  skid_d  = imem.Imem_RD;
                  state_d = HOLD;
               end
            end else if (PC_Enable) begin
               ifid_flush = 1'b1;
               // Address must stay put until the memory answers, so park the target.
               if (redirect) begin
                  redirect_pc_d = target;
                  state_d       = DISCARD;
               end
            end
         end

         HOLD: begin
            if (PC_Enable) begin
               if (redirect) begin
                  ifid_flush = 1'b1;
                  pc_d       = target;
               end else begin
                  ifid_ld = 1'b1;
                  pc_d    = pc_plus4;
               end
               state_d = FETCH;
            end
         end

         DISCARD: begin
            if (PC_Enable) begin
               ifid_flush = 1'b1;
               if (redirect)
                  redirect_pc_d = target;
            end
            if (imem.Imem_Ready) begin
               pc_d    = redirect ? target : redirect_pc_q;
               state_d = FETCH;
            end
         end

         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         skid_q        <= 32'h0;
         redirect_pc_q <= 32'h0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         skid_q        <= skid_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   if_id_reg u_if_id_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld      (ifid_ld),
      .flush   (ifid_flush),
      .instr_i (ifid_instr),
      .pc4_i   (pc_plus4),
      .instr_q (Instr_D),
      .pc4_q   (PC_Plus4_D),
      .valid_q (Valid_D)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose : directed self-checking bench for fetch_stage with an IF/ID scoreboard.
// Latency : n/a.
// Backpressure: n/a.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   typedef struct packed {
      logic        v;
      logic [31:0] i;
      logic [31:0] p;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        PC_Enable, Branch_Taken, Jump, JR;
   logic [31:0] Branch_Target, Jump_Target, JR_Target;
   logic [31:0] Instr_D, PC_Plus4_D;
   logic        Valid_D;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[$];

   fetch_stage_if imem ();

   fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .PC_Enable     (PC_Enable),
      .Branch_Taken  (Branch_Taken),
      .Jump          (Jump),
      .JR            (JR),
      .Branch_Target (Branch_Target),
      .Jump_Target   (Jump_Target),
      .JR_Target     (JR_Target),
      .imem          (imem.master),
      .Instr_D       (Instr_D),
      .PC_Plus4_D    (PC_Plus4_D),
      .Valid_D       (Valid_D)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus; memory returns the word for the current address.
   task automatic drive(input logic en, input logic rdy, input logic br,
                        input logic jmp, input logic jr);
      PC_Enable       = en;
      Branch_Taken    = br;
      Jump            = jmp;
      JR              = jr;
      imem.Imem_Ready = rdy;
      imem.Imem_RD    = rdy ? word_at(imem.Imem_Addr) : 32'hBAD0_BAD0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_valid(input logic [31:0] a);
      exp_q.push_back('{v: 1'b1, i: word_at(a), p: a + 32'd4});
   endtask

   task automatic push_nop();
      exp_q.push_back('{v: 1'b0, i: NOP_INSTR, p: 32'h0});
   endtask

   task automatic check_ifid(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_valid"}, {31'h0, Valid_D}, {31'h0, e.v});
         chk({tag, "_instr"}, Instr_D, e.i);
         chk({tag, "_pc4"}, PC_Plus4_D, e.p);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      Branch_Target = 32'h40;
      Jump_Target   = 32'h80;
      JR_Target     = 32'h100;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #3;
      chk("rst_addr", imem.Imem_Addr, 32'h0);
      chk("rst_req", {31'h0, imem.Imem_Req}, 32'h1);
      chk("rst_valid", {31'h0, Valid_D}, 32'h0);
      chk("rst_instr", Instr_D, 32'h0);
      chk("rst_pc4", PC_Plus4_D, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Straight-line fetch, ready every cycle.
      drive(1, 1, 0, 0, 0); push_valid(32'h0);
      step(); chk("seq_addr4", imem.Imem_Addr, 32'h4); check_ifid("seq0");
      drive(1, 1, 0, 0, 0); push_valid(32'h4);
      step(); chk("seq_addr8", imem.Imem_Addr, 32'h8); check_ifid("seq4");

      // Word at 0x8 arrives during a 2-cycle stall.
      drive(0, 1, 0, 0, 0);
      step();
      chk("hold_state", {30'h0, dut.state_q}, {30'h0, HOLD});
      chk("hold_req", {31'h0, imem.Imem_Req}, 32'h0);
      chk("hold_instr", Instr_D, word_at(32'h4));
      drive(0, 0, 0, 0, 0);
      step();
      chk("hold2_state", {30'h0, dut.state_q}, {30'h0, HOLD});
      chk("hold2_addr", imem.Imem_Addr, 32'h8);
      drive(1, 0, 0, 0, 0); push_valid(32'h8);
      step(); chk("rel_addr", imem.Imem_Addr, 32'hC); check_ifid("release");

      // Branch while ready: wrong-path word squashed.
      drive(1, 1, 1, 0, 0); push_nop();
      step(); chk("br_addr", imem.Imem_Addr, 32'h40); check_ifid("branch");

      // Jump while the fetch is still outstanding.
      drive(1, 0, 0, 1, 0); push_nop();
      step();
      chk("jmp_state", {30'h0, dut.state_q}, {30'h0, DISCARD});
      chk("jmp_addr_hold", imem.Imem_Addr, 32'h40);
      chk("jmp_req", {31'h0, imem.Imem_Req}, 32'h1);
      check_ifid("jmp_wait");
      drive(1, 0, 0, 0, 0); push_nop();
      step(); chk("jmp_addr_hold2", imem.Imem_Addr, 32'h40); check_ifid("jmp_wait2");
      drive(1, 1, 0, 0, 0); push_nop();
      step(); chk("jmp_addr", imem.Imem_Addr, 32'h80); check_ifid("jmp_drop");
      drive(1, 1, 0, 0, 0); push_valid(32'h80);
      step(); chk("post_jmp_addr", imem.Imem_Addr, 32'h84); check_ifid("post_jmp");

      // JR beats Branch_Taken; Jump beats Branch_Taken.
      drive(1, 1, 1, 0, 1); push_nop();
      step(); chk("jr_prio_addr", imem.Imem_Addr, 32'h100); check_ifid("jr_prio");
      // Redirect ignored while stalled; skid word delivered on release.
      drive(0, 1, 0, 0, 1);
      step(); chk("jr_stall_addr", imem.Imem_Addr, 32'h100);
      drive(1, 0, 0, 0, 0); push_valid(32'h100);
      step(); chk("jr_rel_addr", imem.Imem_Addr, 32'h104); check_ifid("jr_rel");
      drive(1, 1, 1, 1, 0); push_nop();
      step(); chk("jmp_prio_addr", imem.Imem_Addr, 32'h80); check_ifid("jmp_prio");

      // PC wrap at the top of the address space.
      Jump_Target = 32'hFFFF_FFFC;
      drive(1, 1, 0, 1, 0); push_nop();
      step(); chk("wrap_top", imem.Imem_Addr, 32'hFFFF_FFFC); check_ifid("wrap_jmp");
      Jump_Target = 32'h80;
      drive(1, 1, 0, 0, 0); push_valid(32'hFFFF_FFFC);
      step(); chk("wrap_addr", imem.Imem_Addr, 32'h0); check_ifid("wrap");

      // In DISCARD a newer redirect overwrites the parked target.
      drive(1, 0, 1, 0, 0); push_nop();
      step(); check_ifid("disc_br");
      drive(1, 0, 0, 1, 0); push_nop();
      step(); check_ifid("disc_jmp");
      drive(1, 1, 0, 0, 0); push_nop();
      step(); chk("disc_newer_addr", imem.Imem_Addr, 32'h80); check_ifid("disc_done");
      // Same-cycle redirect when the stale data lands.
      drive(1, 0, 1, 0, 0); push_nop();
      step(); check_ifid("disc2_br");
      drive(1, 1, 0, 0, 1); push_nop();
      step(); chk("disc_same_addr", imem.Imem_Addr, 32'h100); check_ifid("disc2_done");

      // Asynchronous reset while in DISCARD with a parked target.
      drive(1, 0, 0, 1, 0); push_nop();
      step();
      check_ifid("pre_rst");
      chk("pre_rst_state", {30'h0, dut.state_q}, {30'h0, DISCARD});
      drive(1, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_addr", imem.Imem_Addr, 32'h0);
      chk("arst_state", {30'h0, dut.state_q}, {30'h0, FETCH});
      chk("arst_redir", dut.redirect_pc_q, 32'h0);
      chk("arst_skid", dut.skid_q, 32'h0);
      chk("arst_valid", {31'h0, Valid_D}, 32'h0);
      chk("arst_instr", Instr_D, 32'h0);
      chk("arst_pc4", PC_Plus4_D, 32'h0);
      step();
      rst_n = 1'b1;
      drive(1, 1, 0, 0, 0); push_valid(32'h0);
      step(); chk("post_rst_addr", imem.Imem_Addr, 32'h4); check_ifid("post_rst");

      n_cmp++;
      assert (exp_q.size() == 0) else begin
         n_err++;
         $error("FAIL sb_drain: observed %0d leftover expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
